// File: rtl/score_mem_scheduler.sv
// Arbiter and single owner of the score-history RAM and the high-score RAM.
// Serialises the score writer, the high-score compare engine and the display reader.
module score_mem_scheduler #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_new_run,
  input  logic                  i_wr_req,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ack,
  input  logic                  i_hs_req,
  output logic                  o_hs_done,
  output logic                  o_hs_updated,
  input  logic                  i_disp_req,
  input  logic [ADDR_WIDTH-1:0] i_disp_addr,
  output logic                  o_disp_valid,
  output logic [DATA_WIDTH-1:0] o_disp_data,
  output logic [ADDR_WIDTH-1:0] o_cur_slot,
  output logic [DATA_WIDTH-1:0] o_high_score,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] o_s_address,
  output logic [DATA_WIDTH-1:0] o_s_data,
  output logic                  o_s_wren,
  input  logic [DATA_WIDTH-1:0] i_s_q,
  output logic                  o_h_address,
  output logic [DATA_WIDTH-1:0] o_h_data,
  output logic                  o_h_wren,
  input  logic [DATA_WIDTH-1:0] i_h_q,
  output logic [2:0]            o_state
);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_WRITE   = 3'd2,
    ST_DISP_RD = 3'd3,
    ST_HS_RD   = 3'd4,
    ST_HS_CMP  = 3'd5,
    ST_HS_WR   = 3'd6
  } state_t;

  localparam int CNT_W = (RD_LATENCY < 1) ? 1 : $clog2(RD_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY);

  state_t                r_state;
  logic                  r_hs_pend;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_cur_slot;
  logic [ADDR_WIDTH-1:0] r_s_address;
  logic [DATA_WIDTH-1:0] r_s_data;
  logic                  r_s_wren;
  logic [DATA_WIDTH-1:0] r_h_data;
  logic                  r_h_wren;
  logic                  r_wr_ack;
  logic                  r_hs_done;
  logic                  r_hs_updated;
  logic                  r_disp_valid;
  logic [DATA_WIDTH-1:0] r_disp_data;
  logic [DATA_WIDTH-1:0] r_high_score;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_score;
  logic [DATA_WIDTH-1:0] r_hs_cap;

  logic                  w_hs_active;
  logic                  w_hs_pend;

  // Handshakes: wr_req/disp_req are levels held until their one-cycle
  // wr_ack/disp_valid; hs_req is a pulse latched into a sticky pending flag.
  assign w_hs_active = (r_state == ST_HS_RD) || (r_state == ST_HS_CMP) || (r_state == ST_HS_WR);
  assign w_hs_pend   = r_hs_pend || i_hs_req;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cur_slot <= '0;
    end else if (i_new_run) begin
      r_cur_slot <= r_cur_slot + ADDR_WIDTH'(1);
    end
  end

  // Outputs are registered as the state is entered, so each state's memory
  // controls are on the pins for exactly the cycles spent in that state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_INIT;
      r_hs_pend    <= 1'b0;
      r_cnt        <= '0;
      r_s_address  <= '0;
      r_s_data     <= '0;
      r_s_wren     <= 1'b0;
      r_h_data     <= '0;
      r_h_wren     <= 1'b0;
      r_wr_ack     <= 1'b0;
      r_hs_done    <= 1'b0;
      r_hs_updated <= 1'b0;
      r_disp_valid <= 1'b0;
      r_disp_data  <= '0;
      r_high_score <= '0;
      r_busy       <= 1'b0;
      r_score      <= '0;
      r_hs_cap     <= '0;
    end else begin
      r_s_wren     <= 1'b0;
      r_h_wren     <= 1'b0;
      r_s_data     <= '0;
      r_h_data     <= '0;
      r_wr_ack     <= 1'b0;
      r_hs_done    <= 1'b0;
      r_hs_updated <= 1'b0;
      r_disp_valid <= 1'b0;
      if (i_hs_req && !w_hs_active) begin
        r_hs_pend <= 1'b1;
      end
      case (r_state)
        ST_INIT: begin
          r_h_wren <= 1'b1;
          r_busy   <= 1'b1;
          r_state  <= ST_IDLE;
        end
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_hs_pend) begin
            r_hs_pend   <= 1'b0;
            r_s_address <= r_cur_slot;
            r_busy      <= 1'b1;
            r_state     <= ST_HS_RD;
          end else if (i_wr_req) begin
            r_s_address <= r_cur_slot;
            r_s_data    <= i_wr_data;
            r_s_wren    <= 1'b1;
            r_wr_ack    <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_WRITE;
          end else if (i_disp_req) begin
            r_s_address <= i_disp_addr;
            r_busy      <= 1'b1;
            r_state     <= ST_DISP_RD;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_WRITE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_DISP_RD: begin
          if (r_cnt == CNT_LAST) begin
            r_disp_data  <= i_s_q;
            r_disp_valid <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_HS_RD: begin
          if (r_cnt == CNT_LAST) begin
            r_score  <= i_s_q;
            r_hs_cap <= i_h_q;
            r_state  <= ST_HS_CMP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_HS_CMP: begin
          r_hs_done <= 1'b1;
          // Ties keep the stored high score.
          if (r_score > r_hs_cap) begin
            r_h_wren     <= 1'b1;
            r_h_data     <= r_score;
            r_high_score <= r_score;
            r_hs_updated <= 1'b1;
            r_state      <= ST_HS_WR;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_HS_WR: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_wr_ack     = r_wr_ack;
  assign o_hs_done    = r_hs_done;
  assign o_hs_updated = r_hs_updated;
  assign o_disp_valid = r_disp_valid;
  assign o_disp_data  = r_disp_data;
  assign o_cur_slot   = r_cur_slot;
  assign o_high_score = r_high_score;
  assign o_busy       = r_busy;
  assign o_s_address  = r_s_address;
  assign o_s_data     = r_s_data;
  assign o_s_wren     = r_s_wren;
  assign o_h_address  = 1'b0;
  assign o_h_data     = r_h_data;
  assign o_h_wren     = r_h_wren;
  assign o_state      = r_state;

endmodule

// File: tb/tb_score_mem_scheduler.sv
// Bench for score_mem_scheduler: RAM macro models plus a slot/score/high-score
// reference model, directed steps followed by randomized operations.
module tb_score_mem_scheduler;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          new_run = 1'b0;
  logic          wr_req = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          hs_req = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          wr_ack, hs_done, hs_updated, disp_valid, busy;
  logic [DW-1:0] disp_data, high_score, s_data, h_data;
  logic [AW-1:0] cur_slot, s_address;
  logic          s_wren, h_wren, h_address;
  logic [DW-1:0] s_q, h_q;
  logic [2:0]    dut_state;

  always #5 clk = ~clk;

  score_mem_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_new_run(new_run),
    .i_wr_req(wr_req), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
    .i_hs_req(hs_req), .o_hs_done(hs_done), .o_hs_updated(hs_updated),
    .i_disp_req(disp_req), .i_disp_addr(disp_addr), .o_disp_valid(disp_valid),
    .o_disp_data(disp_data), .o_cur_slot(cur_slot), .o_high_score(high_score),
    .o_busy(busy), .o_s_address(s_address), .o_s_data(s_data), .o_s_wren(s_wren),
    .i_s_q(s_q), .o_h_address(h_address), .o_h_data(h_data), .o_h_wren(h_wren),
    .i_h_q(h_q), .o_state(dut_state)
  );

  // RAM macros: registered address and registered output (two-cycle read).
  logic [DW-1:0] s_mem [256];
  logic [DW-1:0] h_mem [2];
  logic [AW-1:0] s_addr_q;
  logic          h_addr_q;
  logic          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) s_mem[i] <= '0;
      h_mem[0] <= 32'h0000_BEEF;
      h_mem[1] <= 32'h0000_BEEF;
      mem_ready <= 1'b1;
    end else begin
      if (s_wren) s_mem[s_address] <= s_data;
      if (h_wren) h_mem[h_address] <= h_data;
    end
    s_addr_q <= s_address;
    h_addr_q <= h_address;
    s_q <= s_mem[s_addr_q];
    h_q <= h_mem[h_addr_q];
  end

  // Reference model state
  logic [AW-1:0] model_slot = '0;
  logic [DW-1:0] model_mem [256];
  logic [DW-1:0] model_hs = '0;
  logic [DW-1:0] exp_q [$];
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      assert (!(s_wren && h_wren)) else begin
        bad++;
        $error("FAIL wren_exclusive observed=1 expected=0");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_new_run(input int n);
    for (int i = 0; i < n; i++) begin
      new_run = 1'b1;
      tick();
      model_slot = model_slot + 8'd1;
    end
    new_run = 1'b0;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    model_slot = '0;
    model_hs = '0;
    tick();
    check("init_h_wren", 32'(h_wren), 32'd1);
    check("init_h_data", h_data, 32'd0);
    check("init_h_addr", 32'(h_address), 32'd0);
    tick();
    check("init_h_wren_off", 32'(h_wren), 32'd0);
    check("init_busy_low", 32'(busy), 32'd0);
    check("init_cur_slot", 32'(cur_slot), 32'd0);
  endtask

  task automatic do_write(input logic [DW-1:0] d, input bit with_nr);
    logic [AW-1:0] slot_at;
    bit got;
    slot_at = model_slot;
    got = 1'b0;
    wr_req = 1'b1;
    wr_data = d;
    new_run = with_nr;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0 && with_nr) begin
        new_run = 1'b0;
        model_slot = model_slot + 8'd1;
      end
      if (wr_ack) begin
        got = 1'b1;
        break;
      end
    end
    check("wr_ack_seen", 32'(got), 32'd1);
    check("wr_s_wren", 32'(s_wren), 32'd1);
    check("wr_s_address", 32'(s_address), 32'(slot_at));
    check("wr_s_data", s_data, d);
    wr_req = 1'b0;
    model_mem[slot_at] = d;
    tick();
    check("wr_ack_pulse", 32'(wr_ack), 32'd0);
    check("wr_s_data_idle", s_data, 32'd0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input bit nr, output int lat);
    bit got, addr_ok, nr_edge;
    logic [DW-1:0] exp;
    got = 1'b0;
    addr_ok = 1'b1;
    lat = 0;
    disp_req = 1'b1;
    disp_addr = a;
    exp_q.push_back(model_mem[a]);
    for (int i = 0; i < 20; i++) begin
      nr_edge = new_run;
      tick();
      lat++;
      if (nr_edge) model_slot = model_slot + 8'd1;
      if (disp_valid) begin
        got = 1'b1;
        break;
      end
      if (s_address !== a) addr_ok = 1'b0;
      if (nr) new_run = 1'b1;
    end
    new_run = 1'b0;
    disp_req = 1'b0;
    check("rd_valid_seen", 32'(got), 32'd1);
    exp = exp_q.pop_front();
    check("rd_data", disp_data, exp);
    check("rd_addr_stable", 32'(addr_ok), 32'd1);
  endtask

  task automatic do_hs(input bit double_req);
    logic [DW-1:0] score, hw_data;
    bit upd, got;
    int n_hw, extra;
    score = model_mem[model_slot];
    upd = (score > model_hs);
    n_hw = 0;
    hw_data = '0;
    got = 1'b0;
    hs_req = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      hs_req = (double_req && i == 1);
      tick();
      if (h_wren) begin
        n_hw++;
        hw_data = h_data;
      end
      if (hs_done) begin
        got = 1'b1;
        break;
      end
    end
    hs_req = 1'b0;
    check("hs_done_seen", 32'(got), 32'd1);
    check("hs_updated", 32'(hs_updated), 32'(upd));
    check("hs_h_wren_count", 32'(n_hw), upd ? 32'd1 : 32'd0);
    check("hs_h_data", hw_data, upd ? score : 32'd0);
    if (upd) model_hs = score;
    check("hs_high_score", high_score, model_hs);
    tick();
    check("hs_done_pulse", 32'(hs_done), 32'd0);
    if (double_req) begin
      extra = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (hs_done) extra++;
      end
      check("hs_absorbed", 32'(extra), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t_hs, t_wr, t_dp, gap_a, gap_b, n_ev;
    bit hs_upd_seen, exp_upd;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic bh [64];
    for (int i = 0; i < 256; i++) model_mem[i] = '0;

    // Reset values
    repeat (3) tick();
    check("rst_s_wren", 32'(s_wren), 32'd0);
    check("rst_h_wren", 32'(h_wren), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cur_slot", 32'(cur_slot), 32'd0);
    check("rst_high_score", high_score, 32'd0);
    check("rst_wr_ack", 32'(wr_ack), 32'd0);
    #2;
    release_reset();

    // Three runs then a write of 123 into slot 3, read back
    pulse_new_run(3);
    check("slot_after_3", 32'(cur_slot), 32'd3);
    do_write(32'd123, 1'b0);
    do_read(8'd3, 1'b0, lat);
    check("rd_latency", 32'(lat), 32'(RL + 2));
    tick();
    check("rd_data_held", disp_data, 32'd123);

    // High score 50, then 80 replaces it, then an equal 80 does not
    pulse_new_run(1);
    do_write(32'd50, 1'b0);
    do_hs(1'b0);
    pulse_new_run(1);
    do_write(32'd80, 1'b0);
    do_hs(1'b0);
    check("hs_is_80", high_score, 32'd80);
    do_hs(1'b1);

    // All three requesters in one cycle
    d = 32'd300;
    exp_upd = (model_mem[model_slot] > model_hs);
    a = model_slot;
    hs_req = 1'b1;
    wr_req = 1'b1;
    wr_data = d;
    disp_req = 1'b1;
    disp_addr = a;
    t_hs = 0; t_wr = 0; t_dp = 0; hs_upd_seen = 1'b0;
    for (int t = 1; t < 64; t++) begin
      tick();
      bh[t] = busy;
      if (t == 1) hs_req = 1'b0;
      if (hs_done && t_hs == 0) begin
        t_hs = t;
        hs_upd_seen = hs_updated;
      end
      if (wr_ack && t_wr == 0) begin
        t_wr = t;
        wr_req = 1'b0;
        model_mem[a] = d;
      end
      if (disp_valid) begin
        t_dp = t;
        disp_req = 1'b0;
        break;
      end
    end
    hs_req = 1'b0; wr_req = 1'b0; disp_req = 1'b0;
    check("arb_hs_first", 32'(t_hs > 0 && t_hs < t_wr), 32'd1);
    check("arb_wr_second", 32'(t_wr > 0 && t_wr < t_dp), 32'd1);
    check("arb_hs_updated", 32'(hs_upd_seen), 32'(exp_upd));
    check("arb_disp_data", disp_data, d);
    gap_a = 0; gap_b = 0;
    if (t_hs > 0 && t_wr > t_hs && t_dp > t_wr) begin
      for (int t = t_hs; t < t_wr; t++) if (!bh[t]) gap_a++;
      for (int t = t_wr + 1; t < t_dp; t++) if (!bh[t]) gap_b++;
    end
    check("arb_idle_gap_1", 32'(gap_a >= 1), 32'd1);
    check("arb_idle_gap_2", 32'(gap_b >= 1), 32'd1);

    // Randomized operations against the model
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: pulse_new_run($urandom_range(1, 5));
        1: do_write(DW'($urandom_range(0, 2000)), 1'(($urandom_range(0, 1))));
        2: begin
          if ($urandom_range(0, 1) == 1) a = model_slot - AW'($urandom_range(0, 3));
          else a = AW'($urandom_range(0, 255));
          do_read(a, 1'b0, lat);
        end
        default: do_hs(1'b0);
      endcase
    end

    // Slot pointer wrap
    pulse_new_run((256 - int'(model_slot)) % 256);
    check("slot_at_zero", 32'(cur_slot), 32'd0);
    pulse_new_run(256);
    check("slot_wrap", 32'(cur_slot), 32'd0);

    // new_run during a read and together with a write grant
    a = model_slot;
    do_write(32'hA5A5_0001, 1'b0);
    do_read(a, 1'b1, lat);
    check("slot_after_rd_nr", 32'(cur_slot), 32'(model_slot));
    a = model_slot;
    do_write(32'h0000_0777, 1'b1);
    check("slot_after_wr_nr", 32'(cur_slot), 32'(model_slot));
    do_read(a, 1'b0, lat);

    // Reset in the middle of a high-score read
    pulse_new_run(2);
    hs_req = 1'b1;
    tick();
    hs_req = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_s_address", 32'(s_address), 32'd0);
    check("mid_rst_cur_slot", 32'(cur_slot), 32'd0);
    check("mid_rst_high_score", high_score, 32'd0);
    n_ev = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (hs_done || h_wren || s_wren) n_ev++;
    end
    #2;
    release_reset();
    for (int i = 0; i < 15; i++) begin
      tick();
      if (hs_done || disp_valid || wr_ack) n_ev++;
    end
    check("mid_rst_no_done", 32'(n_ev), 32'd0);

    // A pending compare is dropped by reset
    disp_req = 1'b1;
    disp_addr = 8'd9;
    tick();
    disp_req = 1'b0;
    hs_req = 1'b1;
    tick();
    hs_req = 1'b0;
    #2;
    rst_n = 1'b0;
    tick();
    #2;
    release_reset();
    n_ev = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (hs_done || disp_valid) n_ev++;
    end
    check("pend_cleared", 32'(n_ev), 32'd0);

    // High-score RAM was cleared by INIT: a small score now wins
    do_write(32'd7, 1'b0);
    do_hs(1'b0);
    check("hs_after_reinit", high_score, 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
